// File: rtl/dbus_arbiter.sv
// Two-master data bus arbiter: combinational same-cycle grant, round-robin on contention, grant locked across slave waits.
// Zero added latency; losers and waiting owners see mx_wait=1 and must hold their request, and hung transfers abort after TIMEOUT waits.
module dbus_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_rd_en,
   input  logic        m0_wr_en,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wr_data,
   input  logic [3:0]  m0_wr_strobe,
   output logic [31:0] m0_rd_data,
   output logic        m0_wait,
   output logic        m0_err,
   input  logic        m1_rd_en,
   input  logic        m1_wr_en,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wr_data,
   input  logic [3:0]  m1_wr_strobe,
   output logic [31:0] m1_rd_data,
   output logic        m1_wait,
   output logic        m1_err,
   output logic        s_rd_en,
   output logic        s_wr_en,
   output logic [31:0] s_addr,
   output logic [31:0] s_wr_data,
   output logic [3:0]  s_wr_strobe,
   input  logic [31:0] s_rd_data,
   input  logic        s_wait,
   input  logic        s_err,
   output logic [1:0]  grant
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic          owner;
   logic          last_grant;
   logic [CW-1:0] cnt;

   logic req0, req1, owner_req;
   logic sel, sel_vld;
   logic timeout_hit, drop, abort;
   logic sel_rd, sel_wr;
   logic g_wait, g_err;

   always_comb begin
      req0        = m0_rd_en | m0_wr_en;
      req1        = m1_rd_en | m1_wr_en;
      owner_req   = owner ? req1 : req0;
      timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
      drop        = (state == BUSY) && !owner_req;
      abort       = (state == BUSY) && owner_req && timeout_hit;

      sel     = 1'b0;
      sel_vld = 1'b0;
      // Outputs are gated by rst_n so an in-flight transfer is dropped the instant reset asserts
      if (!rst_n) begin
         sel_vld = 1'b0;
      end else if (state == BUSY) begin
         sel     = owner;
         sel_vld = 1'b1;
      end else if (req0 && req1) begin
         sel     = ~last_grant;
         sel_vld = 1'b1;
      end else if (req0 || req1) begin
         sel     = req1 & ~req0;
         sel_vld = 1'b1;
      end

      sel_rd = sel ? m1_rd_en : m0_rd_en;
      sel_wr = sel ? m1_wr_en : m0_wr_en;

      s_rd_en     = 1'b0;
      s_wr_en     = 1'b0;
      s_addr      = '0;
      s_wr_data   = '0;
      s_wr_strobe = '0;
      grant       = 2'b00;
      g_wait      = 1'b0;
      g_err       = 1'b0;
      if (sel_vld) begin
         grant       = sel ? 2'b10 : 2'b01;
         s_addr      = sel ? m1_addr      : m0_addr;
         s_wr_data   = sel ? m1_wr_data   : m0_wr_data;
         s_wr_strobe = sel ? m1_wr_strobe : m0_wr_strobe;
         if (abort) begin
            g_err = 1'b1;
         end else if (!drop) begin
            s_wr_en = sel_wr;
            s_rd_en = sel_rd & ~sel_wr;
            g_wait  = s_wait;
            g_err   = s_err;
         end
      end

      m0_wait = rst_n & req0;
      m1_wait = rst_n & req1;
      m0_err  = 1'b0;
      m1_err  = 1'b0;
      if (sel_vld && !sel) begin
         m0_wait = g_wait;
         m0_err  = g_err;
      end
      if (sel_vld && sel) begin
         m1_wait = g_wait;
         m1_err  = g_err;
      end

      m0_rd_data = s_rd_data;
      m1_rd_data = s_rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  if (s_err || !s_wait) begin
                     last_grant <= sel;
                  end else begin
                     state <= BUSY;
                     owner <= sel;
                     cnt   <= CW'(1);
                  end
               end
            end
            BUSY: begin
               if (!owner_req || timeout_hit || s_err || !s_wait) begin
                  state      <= IDLE;
                  last_grant <= owner;
                  cnt        <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: each driven cycle queues its hand-computed expected outputs,
// and a monitor pops and compares them on the falling edge.
module tb_dbus_arbiter;

   localparam logic [31:0] M0_ADDR = 32'h0000_1000;
   localparam logic [31:0] M0_WDAT = 32'hA0A0_0001;
   localparam logic [3:0]  M0_STRB = 4'h3;
   localparam logic [31:0] M1_ADDR = 32'h0000_2000;
   localparam logic [31:0] M1_WDAT = 32'hB1B1_0002;
   localparam logic [3:0]  M1_STRB = 4'hC;
   localparam logic [31:0] RD_DAT  = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst_n;
   logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
   logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
   logic [3:0]  m0_wr_strobe, m1_wr_strobe;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        m0_wait, m1_wait, m0_err, m1_err;
   logic        s_rd_en, s_wr_en;
   logic [31:0] s_addr, s_wr_data;
   logic [3:0]  s_wr_strobe;
   logic [31:0] s_rd_data;
   logic        s_wait, s_err;
   logic [1:0]  grant;

   typedef struct {
      logic [1:0]  grant;
      logic        rd, wr, w0, w1, e0, e1;
      logic        chk_bus;
      logic [31:0] addr, wdata;
      logic [3:0]  strb;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   dbus_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
      .m0_wr_data(m0_wr_data), .m0_wr_strobe(m0_wr_strobe), .m0_rd_data(m0_rd_data),
      .m0_wait(m0_wait), .m0_err(m0_err),
      .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
      .m1_wr_data(m1_wr_data), .m1_wr_strobe(m1_wr_strobe), .m1_rd_data(m1_rd_data),
      .m1_wait(m1_wait), .m1_err(m1_err),
      .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_wr_data(s_wr_data),
      .s_wr_strobe(s_wr_strobe), .s_rd_data(s_rd_data), .s_wait(s_wait), .s_err(s_err),
      .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vector %0d: got %h, expected %h", nm, vectors, act, exp);
      end
   endtask

   // One bus cycle: rst, m0 rd/wr, m1 rd/wr, slave wait/err, then expected grant, s_rd_en, s_wr_en, waits, errs
   task automatic step(input logic rst, input logic r0, input logic wr0, input logic r1, input logic wr1,
                       input logic sw, input logic se, input logic [1:0] g,
                       input logic erd, input logic ewr, input logic ew0, input logic ew1,
                       input logic ee0, input logic ee1);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst;
      m0_rd_en = r0; m0_wr_en = wr0; m1_rd_en = r1; m1_wr_en = wr1;
      s_wait = sw; s_err = se;
      e.grant = g; e.rd = erd; e.wr = ewr;
      e.w0 = ew0; e.w1 = ew1; e.e0 = ee0; e.e1 = ee1;
      e.chk_bus = erd | ewr | (g == 2'b00);
      e.addr = '0; e.wdata = '0; e.strb = '0;
      if (g == 2'b01) begin
         e.addr = M0_ADDR; e.wdata = M0_WDAT; e.strb = M0_STRB;
      end else if (g == 2'b10) begin
         e.addr = M1_ADDR; e.wdata = M1_WDAT; e.strb = M1_STRB;
      end
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("grant",      32'(grant),   32'(e.grant));
            chk("s_rd_en",    32'(s_rd_en), 32'(e.rd));
            chk("s_wr_en",    32'(s_wr_en), 32'(e.wr));
            chk("m0_wait",    32'(m0_wait), 32'(e.w0));
            chk("m1_wait",    32'(m1_wait), 32'(e.w1));
            chk("m0_err",     32'(m0_err),  32'(e.e0));
            chk("m1_err",     32'(m1_err),  32'(e.e1));
            chk("m0_rd_data", m0_rd_data,   RD_DAT);
            chk("m1_rd_data", m1_rd_data,   RD_DAT);
            if (e.chk_bus) begin
               chk("s_addr",      s_addr,             e.addr);
               chk("s_wr_data",   s_wr_data,          e.wdata);
               chk("s_wr_strobe", 32'(s_wr_strobe),   32'(e.strb));
            end
         end
      end
   end

   initial begin : driver
      rst_n = 1'b0;
      m0_rd_en = 1'b0; m0_wr_en = 1'b0; m1_rd_en = 1'b0; m1_wr_en = 1'b0;
      m0_addr = M0_ADDR; m0_wr_data = M0_WDAT; m0_wr_strobe = M0_STRB;
      m1_addr = M1_ADDR; m1_wr_data = M1_WDAT; m1_wr_strobe = M1_STRB;
      s_rd_data = RD_DAT; s_wait = 1'b0; s_err = 1'b0;

      // reset and idle
      step(0, 0,0,0,0, 0,0, 2'b00, 0,0, 0,0,0,0);
      step(1, 0,0,0,0, 0,0, 2'b00, 0,0, 0,0,0,0);
      // post-reset contention: m0 first, m1 next cycle with no bubble
      step(1, 0,1,0,1, 0,0, 2'b01, 0,1, 0,1,0,0);
      step(1, 0,0,0,1, 0,0, 2'b10, 0,1, 0,0,0,0);
      // single zero-wait read, then rd+wr together resolves to a write
      step(1, 1,0,0,0, 0,0, 2'b01, 1,0, 0,0,0,0);
      step(1, 1,1,0,0, 0,0, 2'b01, 0,1, 0,0,0,0);
      // lock: m1 wins round-robin, slave waits 3 cycles, m0 held off
      step(1, 1,0,0,1, 1,0, 2'b10, 0,1, 1,1,0,0);
      step(1, 1,0,0,1, 1,0, 2'b10, 0,1, 1,1,0,0);
      step(1, 1,0,0,1, 1,0, 2'b10, 0,1, 1,1,0,0);
      step(1, 1,0,0,1, 0,0, 2'b10, 0,1, 1,0,0,0);
      step(1, 1,0,0,0, 0,0, 2'b01, 1,0, 0,0,0,0);
      // timeout after 4 wait cycles
      step(1, 1,0,0,0, 1,0, 2'b01, 1,0, 1,0,0,0);
      step(1, 1,0,0,0, 1,0, 2'b01, 1,0, 1,0,0,0);
      step(1, 1,0,0,0, 1,0, 2'b01, 1,0, 1,0,0,0);
      step(1, 1,0,0,0, 1,0, 2'b01, 1,0, 1,0,0,0);
      step(1, 1,0,0,0, 1,0, 2'b01, 0,0, 0,0,1,0);
      step(1, 0,0,0,0, 1,0, 2'b00, 0,0, 0,0,0,0);
      // slave error completes in IDLE; m1 granted next cycle
      step(1, 0,1,0,0, 0,1, 2'b01, 0,1, 0,0,1,0);
      step(1, 0,0,1,0, 0,0, 2'b10, 1,0, 0,0,0,0);
      // err and wait together: error completion, no lock
      step(1, 1,0,0,0, 1,1, 2'b01, 1,0, 1,0,1,0);
      step(1, 0,0,1,0, 0,0, 2'b10, 1,0, 0,0,0,0);
      // owner drops its request while locked
      step(1, 1,0,0,0, 1,0, 2'b01, 1,0, 1,0,0,0);
      step(1, 0,0,1,0, 1,0, 2'b01, 0,0, 0,1,0,0);
      step(1, 0,0,1,0, 0,0, 2'b10, 1,0, 0,0,0,0);
      // reset asserted mid-wait, then m0 wins first contention again
      step(1, 0,1,0,0, 1,0, 2'b01, 0,1, 1,0,0,0);
      step(1, 0,1,0,0, 1,0, 2'b01, 0,1, 1,0,0,0);
      step(0, 0,1,0,1, 1,0, 2'b00, 0,0, 0,0,0,0);
      step(1, 0,1,0,1, 0,0, 2'b01, 0,1, 0,1,0,0);
      step(1, 0,0,0,1, 0,0, 2'b10, 0,1, 0,0,0,0);
      step(1, 0,0,0,0, 0,0, 2'b00, 0,0, 0,0,0,0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
